// File: rtl/lcm_pkg.sv
// Shared types for the LCM datapath: the X/Y relation codes returned to the controller.
package lcm_pkg;

  typedef enum logic [1:0] {
    CMP_NONE = 2'b00,
    CMP_XLT  = 2'b01,
    CMP_XGT  = 2'b10,
    CMP_EQ   = 2'b11
  } cmp_e;

endpackage

// File: rtl/lcm_acc.sv
// Load/accumulate register: ld && !sel loads the zero-extended operand, ld && sel adds it.
module lcm_acc #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sel,
  input  logic                 i_ld,
  input  logic [WIDTH-1:0]     i_operand,
  output logic [2*WIDTH-1:0]   o_q
);

  localparam int unsigned DW = 2 * WIDTH;

  logic [DW-1:0] r_q;
  logic [DW-1:0] w_ext;

  assign w_ext = DW'(i_operand);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= i_sel ? (r_q + w_ext) : w_ext;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/lcm_datapath.sv
// LCM datapath: operand register, X/Y accumulators, relation code and result holding register.
// Optional step counter and out_iters port are built only with LCM_ITER_COUNT_EN defined.
module lcm_datapath
  import lcm_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ITER_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 in_ready,
  output logic                 proceed,
  input  logic                 xsel,
  input  logic                 ysel,
  input  logic                 xld,
  input  logic                 yld,
  input  logic                 enable,
  output logic [1:0]           comparison,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_lcm,
  output logic                 overrun
`ifdef LCM_ITER_COUNT_EN
  ,
  output logic [ITER_W-1:0]    out_iters
`endif
);

  localparam int unsigned DW = 2 * WIDTH;

  logic             r_op_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_zero;
  logic             r_loaded;
  logic             r_out_valid;
  logic [DW-1:0]    r_out_lcm;
  logic             r_overrun;

  logic [DW-1:0]    w_x;
  logic [DW-1:0]    w_y;
  logic             w_init_ld;
  logic             w_result;
  logic             w_accept;
  cmp_e             w_cmp;

  assign w_init_ld = (xld && !xsel) || (yld && !ysel);
  assign w_result  = enable && r_op_valid;
  // A result is dropped only when the held one is still unconsumed this cycle.
  assign w_accept  = w_result && !(r_out_valid && !out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op_valid <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
    end else if (in_valid && !r_op_valid) begin
      r_op_valid <= 1'b1;
      r_a        <= in_a;
      r_b        <= in_b;
    end else if (w_result) begin
      r_op_valid <= 1'b0;
    end
  end

  lcm_acc #(.WIDTH(WIDTH)) u_x (
    .clk       (clk),
    .rst       (rst),
    .i_sel     (xsel),
    .i_ld      (xld),
    .i_operand (r_a),
    .o_q       (w_x)
  );

  lcm_acc #(.WIDTH(WIDTH)) u_y (
    .clk       (clk),
    .rst       (rst),
    .i_sel     (ysel),
    .i_ld      (yld),
    .i_operand (r_b),
    .o_q       (w_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      if (w_init_ld) begin
        r_zero <= (r_a == '0) || (r_b == '0);
      end
      if (xld || yld) begin
        r_loaded <= 1'b1;
      end
    end
  end

  always_comb begin
    w_cmp = CMP_NONE;
    if (!r_loaded) begin
      w_cmp = CMP_NONE;
    end else if (r_zero || (w_x == w_y)) begin
      w_cmp = CMP_EQ;
    end else if (w_x > w_y) begin
      w_cmp = CMP_XGT;
    end else begin
      w_cmp = CMP_XLT;
    end
  end

  // Result register samples pre-update X, so a same-cycle xld does not leak in.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_lcm   <= '0;
      r_overrun   <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_lcm   <= r_zero ? '0 : w_x;
    end else if (w_result) begin
      r_overrun   <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef LCM_ITER_COUNT_EN
  logic [ITER_W-1:0] r_iter_cnt;
  logic [ITER_W-1:0] r_out_iters;
  logic              w_step;

  assign w_step = (xld && xsel) ^ (yld && ysel);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_iter_cnt  <= '0;
      r_out_iters <= '0;
    end else begin
      if (w_init_ld) begin
        r_iter_cnt <= '0;
      end else if (w_step && (r_iter_cnt != '1)) begin
        r_iter_cnt <= r_iter_cnt + ITER_W'(1);
      end
      if (w_accept) begin
        r_out_iters <= r_iter_cnt;
      end
    end
  end

  assign out_iters = r_out_iters;
`endif

  assign in_ready   = !r_op_valid;
  assign proceed    = r_op_valid;
  assign comparison = w_cmp;
  assign out_valid  = r_out_valid;
  assign out_lcm    = r_out_lcm;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_lcm_datapath.sv
// Directed bench for lcm_datapath with a simple controller model; checks step count when LCM_ITER_COUNT_EN is defined.
module tb_lcm_datapath;

  localparam int unsigned W  = 8;
  localparam int unsigned IW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_ready;
  logic          proceed;
  logic          xsel;
  logic          ysel;
  logic          xld;
  logic          yld;
  logic          enable;
  logic [1:0]    comparison;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] out_lcm;
  logic          overrun;
`ifdef LCM_ITER_COUNT_EN
  logic [IW-1:0] out_iters;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] cmp_log[$];
  bit done;

  lcm_datapath #(.WIDTH(W), .ITER_W(IW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_ready   (in_ready),
    .proceed    (proceed),
    .xsel       (xsel),
    .ysel       (ysel),
    .xld        (xld),
    .yld        (yld),
    .enable     (enable),
    .comparison (comparison),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_lcm    (out_lcm),
    .overrun    (overrun)
`ifdef LCM_ITER_COUNT_EN
    ,
    .out_iters  (out_iters)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic offer(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("offer_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_ops();
    xld = 1'b1; yld = 1'b1; xsel = 1'b0; ysel = 1'b0;
    @(negedge clk);
    xld = 1'b0; yld = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Controller model: step the smaller side until equal, then pulse enable.
  task automatic run_lcm(input bit rdy_at_en, input int max_it, output bit fin);
    cmp_log.delete();
    fin = 1'b0;
    for (int i = 0; i < max_it && !fin; i++) begin
      cmp_log.push_back(comparison);
      case (comparison)
        2'b01: begin xld = 1'b1; xsel = 1'b1; end
        2'b10: begin yld = 1'b1; ysel = 1'b1; end
        2'b11: begin enable = 1'b1; out_ready = rdy_at_en; fin = 1'b1; end
        default: ;
      endcase
      @(negedge clk);
      xld = 1'b0; yld = 1'b0; xsel = 1'b0; ysel = 1'b0;
      enable = 1'b0; out_ready = 1'b0;
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    xsel = 1'b0; ysel = 1'b0; xld = 1'b0; yld = 1'b0; enable = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_proceed", 32'(proceed), 32'd0);
    chk("rst_cmp", 32'(comparison), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_lcm", 32'(out_lcm), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);

    // 4,6 -> 12 after three steps
    offer(8'd4, 8'd6);
    chk("a4_proceed", 32'(proceed), 32'd1);
    chk("a4_in_ready", 32'(in_ready), 32'd0);
    load_ops();
    run_lcm(1'b0, 2000, done);
    chk("a4_done", 32'(done), 32'd1);
    chk("a4_ncmp", 32'(cmp_log.size()), 32'd4);
    chk("a4_cmp0", 32'(cmp_log[0]), 32'd1);
    chk("a4_cmp1", 32'(cmp_log[1]), 32'd2);
    chk("a4_cmp2", 32'(cmp_log[2]), 32'd1);
    chk("a4_cmp3", 32'(cmp_log[3]), 32'd3);
    chk("a4_valid", 32'(out_valid), 32'd1);
    chk("a4_lcm", 32'(out_lcm), 32'd12);
    chk("a4_in_ready", 32'(in_ready), 32'd1);
    chk("a4_overrun", 32'(overrun), 32'd0);
`ifdef LCM_ITER_COUNT_EN
    chk("a4_iters", 32'(out_iters), 32'd3);
`endif
    consume();
    chk("a4_consumed", 32'(out_valid), 32'd0);

    // zero operand short-circuits to equal and forces result 0
    offer(8'd0, 8'd5);
    load_ops();
    run_lcm(1'b0, 2000, done);
    chk("z_done", 32'(done), 32'd1);
    chk("z_cmp0", 32'(cmp_log[0]), 32'd3);
    chk("z_lcm", 32'(out_lcm), 32'd0);
    chk("z_valid", 32'(out_valid), 32'd1);
`ifdef LCM_ITER_COUNT_EN
    chk("z_iters", 32'(out_iters), 32'd0);
`endif
    consume();

    // largest coprime pair: 255*254
    offer(8'd255, 8'd254);
    load_ops();
    run_lcm(1'b0, 2000, done);
    chk("big_done", 32'(done), 32'd1);
    chk("big_lcm", 32'(out_lcm), 32'd64770);
`ifdef LCM_ITER_COUNT_EN
    chk("big_iters", 32'(out_iters), 32'd507);
`endif

    // second result while first still held: dropped, overrun set
    offer(8'd4, 8'd6);
    load_ops();
    run_lcm(1'b0, 2000, done);
    chk("ovr_done", 32'(done), 32'd1);
    chk("ovr_lcm", 32'(out_lcm), 32'd64770);
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_valid", 32'(out_valid), 32'd1);
    chk("ovr_proceed", 32'(proceed), 32'd0);
`ifdef LCM_ITER_COUNT_EN
    chk("ovr_iters", 32'(out_iters), 32'd507);
`endif

    // result coinciding with consumer handshake replaces the held one
    offer(8'd0, 8'd5);
    load_ops();
    run_lcm(1'b1, 2000, done);
    chk("hs_done", 32'(done), 32'd1);
    chk("hs_lcm", 32'(out_lcm), 32'd0);
    chk("hs_valid", 32'(out_valid), 32'd1);
    chk("hs_overrun", 32'(overrun), 32'd1);
    consume();
    chk("hs_consumed", 32'(out_valid), 32'd0);
    chk("hs_sticky", 32'(overrun), 32'd1);

    // enable with xld in the same cycle uses pre-update X
    offer(8'd3, 8'd3);
    load_ops();
    chk("pre_cmp", 32'(comparison), 32'd3);
    enable = 1'b1; xld = 1'b1; xsel = 1'b1;
    @(negedge clk);
    enable = 1'b0; xld = 1'b0; xsel = 1'b0;
    chk("pre_lcm", 32'(out_lcm), 32'd3);
    chk("pre_valid", 32'(out_valid), 32'd1);
`ifdef LCM_ITER_COUNT_EN
    chk("pre_iters", 32'(out_iters), 32'd0);
`endif
    consume();

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_overrun", 32'(overrun), 32'd0);
    chk("rst2_valid", 32'(out_valid), 32'd0);

    // spurious enable with no operands held
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    chk("spur_valid", 32'(out_valid), 32'd0);
    chk("spur_overrun", 32'(overrun), 32'd0);

    // reset after three steps discards the run
    offer(8'd4, 8'd6);
    load_ops();
    run_lcm(1'b0, 3, done);
    chk("mid_not_done", 32'(done), 32'd0);
    chk("mid_steps", 32'(cmp_log.size()), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_cmp", 32'(comparison), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_proceed", 32'(proceed), 32'd0);
    chk("mid_valid", 32'(out_valid), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("mid_no_result", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcm_datapath.md
LCM_DATAPATH -- requirements
Module: lcm_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the operand width in bits.
REQ-002 SHALL have parameter ITER_W, default 16, giving the iteration counter width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: operand pair offered.
REQ-006 SHALL have port in_a, input, WIDTH bits: operand A.
REQ-007 SHALL have port in_b, input, WIDTH bits: operand B.
REQ-008 SHALL have port in_ready, output, 1 bit: operand register empty.
REQ-009 SHALL have port proceed, output, 1 bit: operand pair held, so the controller may start.
REQ-010 SHALL have ports xsel, ysel, xld, yld, enable, inputs, 1 bit each: controller commands.
REQ-011 SHALL have port comparison, output, 2 bits: X/Y relation code returned to the controller.
REQ-012 SHALL have port out_valid, output, 1 bit: result held.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-014 SHALL have port out_lcm, output, 2*WIDTH bits: result value.
REQ-015 SHALL have port overrun, output, 1 bit: sticky flag, set when a result is lost.
REQ-016 SHALL have port out_iters, output, ITER_W bits: step count; present only under LCM_ITER_COUNT_EN.

Function
REQ-017 SHALL capture in_a and in_b into the operand register and set op_valid when in_valid && in_ready; in_ready = !op_valid; proceed = op_valid.
REQ-018 SHALL update X (2*WIDTH bits) as follows: xld && !xsel -> X <= zero-extended A; xld && xsel -> X <= X + A; Y and B follow the same rule using yld and ysel; no ld -> hold.
REQ-019 SHALL set a registered zero flag on any load with xsel=0 or ysel=0, equal to (A==0 || B==0).
REQ-020 SHALL drive comparison combinationally: zero flag set or X==Y -> 2'b11; X>Y -> 2'b10; X<Y -> 2'b01; 2'b00 only before the first load after reset.
REQ-021 SHALL treat enable && op_valid as a result event: out_lcm <= current X (the zero flag forces 0), out_valid <= 1, op_valid <= 0.
REQ-022 SHALL use the pre-update X for the result when enable and xld occur in the same cycle.
REQ-023 SHALL ignore enable when op_valid=0 (spurious enable): no result is written and no flag changes.
REQ-024 SHALL clear out_valid on out_valid && out_ready; out_lcm SHALL hold until then.
REQ-025 SHALL, on a result event while out_valid=1 && !out_ready, drop the new result, keep the old one, and set overrun.
REQ-026 SHALL accept a new result when a result event coincides with a consumer handshake; out_valid stays 1.
REQ-027 SHALL allow an operand capture in the same cycle as a result event: in_ready is 0 that cycle, so capture happens on the next cycle.
REQ-028 SHALL ensure the sum of X + A cannot exceed 2*WIDTH bits within a legal run; there is no overflow detection.

Reset
REQ-029 SHALL, while rst=1, clear op_valid, X, Y, A, B, the zero flag, out_valid, out_lcm, overrun and the iteration counter, and mark the block as not yet loaded.
REQ-030 SHALL, with rst=1 in mid-computation, discard the run and produce no result.
REQ-031 SHALL drive these outputs during and after reset: in_ready=1, proceed=0, comparison=2'b00, out_valid=0.

Configuration
REQ-032 SHALL, with LCM_ITER_COUNT_EN defined, count cycles with (xld&&xsel) xor (yld&&ysel), saturating at 2^ITER_W-1, clear the count on a sel=0 load, and copy the count to out_iters on every accepted result event.
REQ-033 SHALL, with LCM_ITER_COUNT_EN undefined, omit the counter, the register and the out_iters port; all other behaviour is unchanged.

Structure
REQ-034 SHALL place the comparison codes CMP_NONE, CMP_XGT, CMP_XLT and CMP_EQ in package lcm_pkg.
REQ-035 SHALL use one sub-module, lcm_acc (a load/accumulate register with sel/ld), instantiated twice, for X and Y.

Verification
REQ-036 SHALL verify: A=4, B=6 under a controller model -> out_lcm=12, out_iters=3, comparison sequence 01,10,01,11.
REQ-037 SHALL verify: A=0, B=5 -> comparison=11 on the first compare, out_lcm=0, out_iters=0.
REQ-038 SHALL verify: A=255, B=254 -> out_lcm=64770, out_iters=507.
REQ-039 SHALL verify: two results with out_ready=0 -> first result retained, overrun=1 until reset.
REQ-040 SHALL verify: enable pulse with op_valid=0 -> out_valid stays 0 and overrun stays 0.
REQ-041 SHALL verify: rst asserted after three steps -> next cycle comparison=00, in_ready=1, no result.
